// File: rtl/agc_gain_controller_if.sv
// Sample stream bundle for the AGC gain controller: input and output valid/ready channels.
// No logic; a pure signal bundle.
// Modports: slave = controller side, master = sample source / sink side.
interface agc_gain_controller_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_i;
    logic [15:0] in_q;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_i;
    logic [15:0] out_q;

    modport slave (
        input  in_valid, in_i, in_q, out_ready,
        output in_ready, out_valid, out_i, out_q
    );

    modport master (
        output in_valid, in_i, in_q, out_ready,
        input  in_ready, out_valid, out_i, out_q
    );
endinterface

// File: rtl/agc_gain_controller.sv
// AGC loop controller: scales Q8.8 samples by gain, estimates |z|, adapts gain toward target_R.
// Latency: out_valid rises 3 edges after input acceptance; 5-cycle minimum sample period.
// Backpressure: one sample in flight; out_ready=0 holds OUT indefinitely, in_ready=0 outside IDLE.
// Optional macro AGC_LOCK_DETECT_EN builds the lock counter; otherwise locked is tied to 0.
module agc_gain_controller #(
    parameter int          MU_SHIFT    = 4,
    parameter logic [15:0] GAIN_INIT   = 16'h0100,
    parameter logic [15:0] GAIN_MIN    = 16'h0010,
    parameter logic [15:0] GAIN_MAX    = 16'h4000,
    parameter logic [15:0] LOCK_THRESH = 16'h0010,
    parameter int          LOCK_COUNT  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [15:0]               target_R,
    agc_gain_controller_if.slave      ifc,
    output logic [15:0]               gain,
    output logic [15:0]               error,
    output logic                      locked
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCALE  = 3'd1,
        MAG    = 3'd2,
        UPDATE = 3'd3,
        OUT    = 3'd4
    } state_t;

    localparam int          CW       = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0] LOCK_MAX = CW'(LOCK_COUNT);

    state_t state, state_nxt;

    logic signed [15:0] samp_i, samp_q;
    logic [15:0]        out_i_r, out_q_r;
    logic [15:0]        mag_r;
    logic [15:0]        gain_r;
    logic [15:0]        error_r;

    // Q16.16 product -> Q8.8, saturating when bits [31:23] are not a pure sign extension.
    function automatic logic [15:0] sat_q(input logic signed [31:0] p);
        if ((p[31:23] == 9'h000) || (p[31:23] == 9'h1FF))
            return p[23:8];
        else if (p[31])
            return 16'h8000;
        else
            return 16'h7FFF;
    endfunction

    // Absolute value with the most negative code folded to the most positive.
    function automatic logic [15:0] abs16(input logic [15:0] v);
        if (v == 16'h8000)
            return 16'h7FFF;
        else if (v[15])
            return ~v + 16'd1;
        else
            return v;
    endfunction

    // Scaling: gain is always positive, so a signed multiply is exact.
    logic signed [31:0] prod_i, prod_q;
    assign prod_i = samp_i * $signed(gain_r);
    assign prod_q = samp_q * $signed(gain_r);

    // Alpha-max-beta-min magnitude of the registered scaled sample.
    logic [15:0] abs_i, abs_q, mag_max, mag_min, mag_nxt;
    logic [16:0] mag_sum;
    assign abs_i   = abs16(out_i_r);
    assign abs_q   = abs16(out_q_r);
    assign mag_max = (abs_i >= abs_q) ? abs_i : abs_q;
    assign mag_min = (abs_i >= abs_q) ? abs_q : abs_i;
    assign mag_sum = {1'b0, mag_max} + {2'b00, mag_min[15:1]};
    assign mag_nxt = (mag_sum > 17'h07FFF) ? 16'h7FFF : mag_sum[15:0];

    // Error R - |z| at 17 bits, saturated to 16.
    logic signed [16:0] err17;
    logic signed [15:0] err16;
    assign err17 = $signed({target_R[15], target_R}) - $signed({1'b0, mag_r});
    assign err16 = (err17 > 17'sh07FFF)  ? 16'sh7FFF :
                   (err17 < -17'sh08000) ? 16'sh8000 : err17[15:0];

    // Gain step and clamp at 17 bits; both operands are small enough that no wrap occurs.
    logic signed [15:0] step;
    logic signed [16:0] gain_sum;
    logic [15:0]        gain_nxt;
    assign step     = err16 >>> MU_SHIFT;
    assign gain_sum = $signed({1'b0, gain_r}) + $signed({step[15], step});
    assign gain_nxt = (gain_sum < $signed({1'b0, GAIN_MIN})) ? GAIN_MIN :
                      (gain_sum > $signed({1'b0, GAIN_MAX})) ? GAIN_MAX : gain_sum[15:0];

    // In-tolerance test for the lock detector, computed on the error being registered.
    logic [16:0] err_abs;
    logic        lock_hit;
    assign err_abs  = err16[15] ? 17'(-err17) : {1'b0, err16};
    assign lock_hit = enable && (err_abs <= {1'b0, LOCK_THRESH}) && (err16 == err17[15:0] || !err16[15]);

    // State register; reset drops any in-flight sample.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt     = state;
        ifc.in_ready  = 1'b0;
        ifc.out_valid = 1'b0;
        case (state)
            IDLE: begin
                ifc.in_ready = !rst;
                if (ifc.in_valid) state_nxt = SCALE;
            end
            SCALE:  state_nxt = MAG;
            MAG:    state_nxt = UPDATE;
            UPDATE: state_nxt = OUT;
            OUT: begin
                ifc.out_valid = 1'b1;
                if (ifc.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers, one pipeline step per FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_i  <= '0;
            samp_q  <= '0;
            out_i_r <= '0;
            out_q_r <= '0;
            mag_r   <= '0;
            error_r <= '0;
            gain_r  <= GAIN_INIT;
        end else begin
            case (state)
                IDLE: if (ifc.in_valid) begin
                    samp_i <= $signed(ifc.in_i);
                    samp_q <= $signed(ifc.in_q);
                end
                SCALE: begin
                    out_i_r <= sat_q(prod_i);
                    out_q_r <= sat_q(prod_q);
                end
                MAG: mag_r <= mag_nxt;
                UPDATE: begin
                    error_r <= err16;
                    if (enable) gain_r <= gain_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef AGC_LOCK_DETECT_EN
    logic [CW-1:0] lock_cnt;

    // Consecutive in-tolerance counter, evaluated only on UPDATE edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (state == UPDATE) begin
            if (lock_hit) begin
                if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 1'b1;
                locked <= (lock_cnt >= LOCK_MAX - 1'b1);
            end else begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^{lock_hit, LOCK_MAX};
    assign locked      = 1'b0;
`endif

    assign ifc.out_i = out_i_r;
    assign ifc.out_q = out_q_r;
    assign gain      = gain_r;
    assign error     = error_r;

endmodule

// File: tb/tb_agc_gain_controller.sv
// Directed bench for agc_gain_controller: hand-computed vectors over reset, adaptation,
// clamping/saturation, backpressure and (when AGC_LOCK_DETECT_EN is defined) lock detection.
module tb_agc_gain_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] target_R;
    logic [15:0] gain, error;
    logic        locked;
    int          checks   = 0;
    int          failures = 0;
    int          lat;

    agc_gain_controller_if ifc ();

    agc_gain_controller dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .target_R (target_R),
        .ifc      (ifc.slave),
        .gain     (gain),
        .error    (error),
        .locked   (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one sample in IDLE, then wait (bounded) for out_valid; returns at E3+#1.
    task automatic send(input logic [15:0] si, input logic [15:0] sq, output int l);
        @(negedge clk);
        chk("in_ready_idle", {31'b0, ifc.in_ready}, 32'd1);
        ifc.in_i     = si;
        ifc.in_q     = sq;
        ifc.in_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        l = 0;
        while (!ifc.out_valid && l < 20) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    // Complete the output handshake (out_ready assumed high) and confirm return to IDLE.
    task automatic drain();
        @(posedge clk);
        #1;
        chk("idle_after_hs", {30'b0, ifc.in_ready, ifc.out_valid}, 32'h2);
    endtask

    initial begin
        rst           = 1'b1;
        enable        = 1'b1;
        target_R      = 16'h0100;
        ifc.in_valid  = 1'b0;
        ifc.in_i      = '0;
        ifc.in_q      = '0;
        ifc.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  {31'b0, ifc.in_ready},  32'd0);
        chk("rst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
        chk("rst_gain",      {16'b0, gain},          32'h0100);
        chk("rst_error",     {16'b0, error},         32'h0);
        chk("rst_out",       {ifc.out_i, ifc.out_q}, 32'h0);
        chk("rst_locked",    {31'b0, locked},        32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_in_ready",  {31'b0, ifc.in_ready},  32'd1);

        // Unity: gain 1.0, target 1.0
        send(16'h0100, 16'h0000, lat);
        chk("unity_lat",   lat,                      32'd3);
        chk("unity_out",   {ifc.out_i, ifc.out_q},   32'h0100_0000);
        chk("unity_err",   {16'b0, error},           32'h0);
        chk("unity_gain",  {16'b0, gain},            32'h0100);
        drain();

        // Adapt up with gain frozen
        enable   = 1'b0;
        target_R = 16'h0200;
        send(16'h0100, 16'h0000, lat);
        chk("frz_err",  {16'b0, error}, 32'h0100);
        chk("frz_gain", {16'b0, gain},  32'h0100);
        drain();

        // Adapt up: step 0x100>>>4 = 0x10
        enable = 1'b1;
        send(16'h0100, 16'h0000, lat);
        chk("up_out",  {ifc.out_i, ifc.out_q}, 32'h0100_0000);
        chk("up_err",  {16'b0, error},         32'h0100);
        chk("up_gain", {16'b0, gain},          32'h0110);
        drain();

        // Negative sample, gain 0x110: out=(-0x110,0x88), mag=0x110+0x44=0x154,
        // err=0x80-0x154=-0xD4, step=-0xE, gain=0x102
        target_R = 16'h0080;
        send(16'hFF00, 16'h0080, lat);
        chk("neg_out",  {ifc.out_i, ifc.out_q}, 32'hFEF0_0088);
        chk("neg_err",  {16'b0, error},         32'hFF2C);
        chk("neg_gain", {16'b0, gain},          32'h0102);
        drain();

        // Clamp: large positive error drives gain to GAIN_MAX
        target_R = 16'h7FFF;
        for (int k = 0; k < 12; k++) begin
            send(16'h0001, 16'h0000, lat);
            drain();
        end
        chk("clamp_gain", {16'b0, gain}, 32'h4000);

        // Saturation: both rails, mag saturates at 0x7FFF so error=0
        send(16'h7FFF, 16'h8000, lat);
        chk("sat_out",  {ifc.out_i, ifc.out_q}, 32'h7FFF_8000);
        chk("sat_err",  {16'b0, error},         32'h0);
        chk("sat_gain", {16'b0, gain},          32'h4000);
        drain();

        // Backpressure: out=(1*0x4000>>8, 0)=(0x40,0), err=0x7FFF-0x40=0x7FBF
        ifc.out_ready = 1'b0;
        send(16'h0001, 16'h0000, lat);
        chk("bp_lat", lat, 32'd3);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ifc.in_valid = 1'b1;
            ifc.in_i     = 16'h1234;
            ifc.in_q     = 16'h5678;
            chk("bp_hold", {ifc.out_valid, ifc.in_ready, 14'b0, ifc.out_i}, 32'h8000_0040);
            chk("bp_err",  {16'b0, error}, 32'h7FBF);
        end
        @(negedge clk);
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", {30'b0, ifc.in_ready, ifc.out_valid}, 32'h2);

        // Reset mid-SCALE: gain back to init, sample dropped
        @(negedge clk);
        ifc.in_i     = 16'h0100;
        ifc.in_q     = 16'h0000;
        ifc.in_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_gain",  {16'b0, gain},           32'h0100);
        chk("mid_rst_vld",   {30'b0, ifc.out_valid, ifc.in_ready}, 32'h0);
        chk("mid_rst_err",   {16'b0, error},          32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rel_ready", {31'b0, ifc.in_ready},   32'd1);
        chk("mid_rel_lock",  {31'b0, locked},         32'd0);

        // Lock: 16 unity samples, then one with error 0x20
        target_R = 16'h0100;
        for (int k = 0; k < 16; k++) begin
            send(16'h0100, 16'h0000, lat);
`ifdef AGC_LOCK_DETECT_EN
            chk("lock_seq", {31'b0, locked}, (k == 15) ? 32'd1 : 32'd0);
`else
            chk("lock_seq", {31'b0, locked}, 32'd0);
`endif
            drain();
        end
        target_R = 16'h0120;
        send(16'h0100, 16'h0000, lat);
        chk("unlock_err",  {16'b0, error},  32'h0020);
        chk("unlock_gain", {16'b0, gain},   32'h0102);
        chk("unlock_lock", {31'b0, locked}, 32'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
